// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Decodes a small RV32I subset into ALU operands and an operation code, then
// queues the result in a 2-entry skid FIFO toward the ALU stage.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of all buffered entries
//   in_valid     instruction/operand bundle present
//   in_ready     bundle accepted when in_valid && in_ready
//   instr        raw RV32I instruction word
//   rs1_data     register-file read port 1
//   rs2_data     register-file read port 2
//   out_valid    SrcA/SrcB/Operation valid toward the ALU
//   out_ready    ALU consumes when out_valid && out_ready
//   SrcA, SrcB   ALU operands from the head entry
//   Operation    ALU operation code from the head entry
//   illegal      head entry is an unsupported instruction
//   illegal_cnt  saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [15:0]              illegal_cnt
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL  = OPCODE_LENGTH'(4'b1111);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
        logic [OPCODE_LENGTH-1:0] op;
        logic                     ill;
    } entry_t;

    // ---------------------------------------------------------------- decode
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_s;
    entry_t                w_entry;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};

    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_entry.src_a = rs1_data;
        w_entry.src_b = '0;
        w_entry.op    = OP_ILL;
        w_entry.ill   = 1'b1;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  begin w_entry.op = OP_ADD; w_entry.ill = 1'b0; end
                        3'b111:  begin w_entry.op = OP_AND; w_entry.ill = 1'b0; end
                        3'b110:  begin w_entry.op = OP_OR;  w_entry.ill = 1'b0; end
                        3'b100:  begin w_entry.op = OP_XOR; w_entry.ill = 1'b0; end
                        default: ;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_entry.op  = OP_SUB;
                    w_entry.ill = 1'b0;
                end
                if (!w_entry.ill) w_entry.src_b = rs2_data;
            end
            7'b0010011: begin
                if (w_funct3 == 3'b000) begin
                    // The ALU slices the immediate out of the raw word itself.
                    w_entry.src_b = DATA_WIDTH'(instr);
                    w_entry.op    = OP_ADDI;
                    w_entry.ill   = 1'b0;
                end
            end
            7'b1100011: begin
                if (w_funct3 == 3'b000) begin
                    w_entry.src_b = rs2_data;
                    w_entry.op    = OP_BEQ;
                    w_entry.ill   = 1'b0;
                end
            end
            7'b0000011: begin
                if (w_funct3 == 3'b010) begin
                    w_entry.src_b = w_imm_i;
                    w_entry.op    = OP_ADD;
                    w_entry.ill   = 1'b0;
                end
            end
            7'b0100011: begin
                if (w_funct3 == 3'b010) begin
                    w_entry.src_b = w_imm_s;
                    w_entry.op    = OP_ADD;
                    w_entry.ill   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ FIFO
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [15:0] r_illegal_cnt;
    entry_t      r_mem [2];
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;

    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    // Flush wins over both handshakes; nothing is written or consumed.
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_head    = r_mem[r_rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable once written, and empty-FIFO outputs are forced to zero below.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= 16'd0;
        end else if (w_push && w_entry.ill && r_illegal_cnt != 16'hFFFF) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign SrcA        = out_valid ? w_head.src_a : '0;
    assign SrcB        = out_valid ? w_head.src_b : '0;
    assign Operation   = out_valid ? w_head.op    : '0;
    assign illegal     = out_valid && w_head.ill;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Directed and random stimulus for alu_issue. Expected outputs come from a
// queue-based reference model whose decoder is written from the instruction
// table; every cycle the DUT outputs are compared against the model head.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        illegal;
    logic [15:0] illegal_cnt;

    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Operation   (Operation),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        model_q[$];
    logic [15:0] model_ill_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder, written straight from the instruction table.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        opc   = w[6:0];
        f3    = w[14:12];
        f7    = w[31:25];
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        e     = '{a: a, b: 32'd0, op: 4'hF, ill: 1'b1};
        if      (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) e = '{a, b, 4'b0010, 1'b0};
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) e = '{a, b, 4'b0000, 1'b0};
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) e = '{a, b, 4'b0001, 1'b0};
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd4) e = '{a, b, 4'b0101, 1'b0};
        else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) e = '{a, b, 4'b0110, 1'b0};
        else if (opc == 7'h13 && f3 == 3'd0)                e = '{a, w, 4'b1100, 1'b0};
        else if (opc == 7'h63 && f3 == 3'd0)                e = '{a, b, 4'b1000, 1'b0};
        else if (opc == 7'h03 && f3 == 3'd2)                e = '{a, imm_i, 4'b0010, 1'b0};
        else if (opc == 7'h23 && f3 == 3'd2)                e = '{a, imm_s, 4'b0010, 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0: return {7'h00, r[24:15], 3'd0, r[11:7], 7'h33};
            1: return {7'h00, r[24:15], 3'd7, r[11:7], 7'h33};
            2: return {7'h00, r[24:15], 3'd6, r[11:7], 7'h33};
            3: return {7'h00, r[24:15], 3'd4, r[11:7], 7'h33};
            4: return {7'h20, r[24:15], 3'd0, r[11:7], 7'h33};
            5: return {r[31:15], 3'd0, r[11:7], 7'h13};
            6: return {r[31:15], 3'd0, r[11:7], 7'h63};
            7: return {r[31:15], 3'd2, r[11:7], 7'h03};
            8: return {r[31:15], 3'd2, r[11:7], 7'h23};
            default: return r;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare all outputs
    // with the model head, then advance the model at the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] w, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic fl);
        exp_t h;
        exp_t nd;
        logic push;
        logic pop;
        @(negedge clk);
        in_valid  = iv;
        instr     = w;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        h = (model_q.size() > 0) ? model_q[0] : '0;
        check("in_ready",    32'(in_ready),    32'(model_q.size() < 2));
        check("out_valid",   32'(out_valid),   32'(model_q.size() > 0));
        check("SrcA",        SrcA,             h.a);
        check("SrcB",        SrcB,             h.b);
        check("Operation",   32'(Operation),   32'(h.op));
        check("illegal",     32'(illegal),     32'(h.ill));
        check("illegal_cnt", 32'(illegal_cnt), 32'(model_ill_cnt));
        push = iv && (model_q.size() < 2) && !fl;
        pop  = (model_q.size() > 0) && ordy && !fl;
        nd   = ref_decode(w, a, b);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(nd);
                if (nd.ill && model_ill_cnt != 16'hFFFF) model_ill_cnt++;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    // Direct check of the current head a moment after the rising edge.
    task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic ill);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_SrcA"},  SrcA, a);
        check({tag, "_SrcB"},  SrcB, b);
        check({tag, "_op"},    32'(Operation), 32'(op));
        check({tag, "_ill"},   32'(illegal), 32'(ill));
    endtask

    task automatic expect_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),    32'd1);
        check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_SrcA"},      SrcA,             32'd0);
        check({tag, "_SrcB"},      SrcB,             32'd0);
        check({tag, "_op"},        32'(Operation),   32'd0);
        check({tag, "_ill"},       32'(illegal),     32'd0);
        check({tag, "_cnt"},       32'(illegal_cnt), 32'd0);
    endtask

    initial begin
        logic [31:0] alu_res;
        rst_n         = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        instr         = 32'd0;
        rs1_data      = 32'd0;
        rs2_data      = 32'd0;
        out_ready     = 1'b0;
        model_ill_cnt = 16'd0;

        // Reset state
        #2;
        expect_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);

        // ADD x3,x1,x2 appears the cycle after acceptance
        cycle(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        expect_head("add", 32'd5, 32'd7, 4'b0010, 1'b0);
        idle(1'b1);

        // ADDI imm=-1: raw word passed through, ALU result 10 + (-1)
        cycle(1'b1, 32'hFFF08093, 32'd10, 32'h1234, 1'b1, 1'b0);
        expect_head("addi", 32'd10, 32'hFFF08093, 4'b1100, 1'b0);
        alu_res = SrcA + {{20{SrcB[31]}}, SrcB[31:20]};
        check("addi_result", alu_res, 32'd9);
        idle(1'b1);

        // Back-pressure: three pushes, only two accepted, head held
        cycle(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h4020_81B3, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_F1B3, 32'd5, 32'd6, 1'b0, 1'b0);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        expect_head("held", 32'd1, 32'd2, 4'b0010, 1'b0);
        cycle(1'b1, 32'h0020_E1B3, 32'd7, 32'd8, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Full with in_valid and out_ready: pop only, then push+pop across wrap
        cycle(1'b1, 32'h0020_C1B3, 32'h11, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h0040_A103, 32'h33, 32'h44, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_81B3, 32'h55, 32'h66, 1'b1, 1'b0);
        #1;
        check("after_pop_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'hFE20_AE23, 32'h77, 32'h88, 1'b1, 1'b0);
        cycle(1'b1, 32'h0020_8463, 32'h99, 32'hAA, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Illegal word, then flush with two entries while pushing another illegal
        cycle(1'b1, 32'h0000_0000, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0);
        expect_head("illegal", 32'hDEAD, 32'd0, 4'b1111, 1'b1);
        check("illegal_cnt_1", 32'(illegal_cnt), 32'd1);
        cycle(1'b1, 32'h002081B3, 32'd1, 32'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'd2, 32'd2, 1'b1, 1'b1);
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_cnt_kept",  32'(illegal_cnt), 32'd1);
        idle(1'b1);

        // Asynchronous reset while full
        cycle(1'b1, 32'h002081B3, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'd5, 32'd6, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_state("async_reset");
        model_q.delete();
        model_ill_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width; only 32 is supported.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of Operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  instruction/operand bundle present.
REQ-007 in_ready  output  1  bundle accepted when in_valid && in_ready.
REQ-008 instr  input  32  raw RV32I instruction word.
REQ-009 rs1_data  input  DATA_WIDTH  register-file read port 1.
REQ-010 rs2_data  input  DATA_WIDTH  register-file read port 2.
REQ-011 out_valid  output  1  SrcA/SrcB/Operation valid toward ALU.
REQ-012 out_ready  input  1  ALU stage consumes when out_valid && out_ready.
REQ-013 SrcA  output  DATA_WIDTH  ALU operand A.
REQ-014 SrcB  output  DATA_WIDTH  ALU operand B.
REQ-015 Operation  output  OPCODE_LENGTH  ALU operation code.
REQ-016 illegal  output  1  head entry is an unsupported instruction.
REQ-017 illegal_cnt  output  16  saturating count of accepted illegal instructions.

Function
REQ-018 Decode on acceptance; each entry stores {SrcA, SrcB, Operation, illegal}; SrcA = rs1_data for every entry.
REQ-019 opcode 0110011, funct7 0000000: funct3 000 -> 0010 ADD, 111 -> 0000 AND, 110 -> 0001 OR, 100 -> 0101 XOR; SrcB = rs2_data.
REQ-020 opcode 0110011, funct7 0100000, funct3 000 -> 0110 SUB; SrcB = rs2_data.
REQ-021 opcode 0010011, funct3 000 (ADDI) -> 1100; SrcB = instr unmodified, since the ALU extracts SrcB[31:20] and sign-extends it.
REQ-022 opcode 1100011, funct3 000 (BEQ) -> 1000; SrcB = rs2_data.
REQ-023 opcode 0000011, funct3 010 (LW) -> 0010; SrcB = sign-extended instr[31:20].
REQ-024 opcode 0100011, funct3 010 (SW) -> 0010; SrcB = sign-extended {instr[31:25], instr[11:7]}.
REQ-025 Any other encoding: Operation = 1111, SrcB = 0, illegal = 1; the entry still flows through the handshake.
REQ-026 Storage is a 2-entry FIFO (skid buffer) with 2-bit occupancy count 0..2 and 1-bit read/write pointers that wrap.
REQ-027 in_ready = (count < 2), combinational from registered state only; independent of in_valid and out_ready.
REQ-028 out_valid = (count > 0); SrcA/SrcB/Operation/illegal driven from the head entry and held stable while out_valid && !out_ready.
REQ-029 Latency: a bundle accepted in cycle N appears at the outputs in cycle N+1 when the FIFO was empty.
REQ-030 Simultaneous push and pop: count unchanged and both pointers advance; at count=2 a push is impossible because in_ready=0.
REQ-031 When out_valid=0, outputs SrcA=0, SrcB=0, Operation=0000 and illegal=0.
REQ-032 flush: next cycle count=0 and pointers=0; any push in the flush cycle is discarded; illegal_cnt is unaffected; flush overrides push and pop.
REQ-033 illegal_cnt increments by 1 on each accepted illegal bundle (not when flush is active) and saturates at 16'hFFFF.

Reset
REQ-034 rst_n=0 forces immediately: count=0, pointers=0, illegal_cnt=0, out_valid=0, in_ready=1, SrcA/SrcB=0, Operation=0000, illegal=0.
REQ-035 Reset mid-transfer drops all buffered entries; no output handshake completes in the cycle rst_n is released.

Verification
REQ-036 ADD x3,x1,x2 (instr 32'h002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, SrcA=5, SrcB=7, Operation=0010.
REQ-037 ADDI with imm=-1 (instr 32'hFFF08093), rs1=10 -> Operation=1100, SrcB=32'hFFF08093; the ALU result checks as 9.
REQ-038 out_ready=0, push three bundles back-to-back -> first two accepted, in_ready=0 on the third, head outputs stable; then out_ready=1 -> bundles drain in order.
REQ-039 Full FIFO, in_valid=1, out_ready=1 in the same cycle -> one pop, then in_ready=1, and order is preserved across pointer wrap.
REQ-040 instr 32'h00000000 accepted -> Operation=1111, illegal=1, illegal_cnt=1; flush with 2 entries -> out_valid=0 next cycle.
REQ-041 rst_n pulsed low asynchronously while count=2 -> outputs reach their reset values before the next clk edge.
